// File: rtl/gpio_in_debounce_pkg.sv
// Shared definitions for the GPIO input path: default timing, port bit layout and the debounce state type.
package gpio_in_debounce_pkg;

   localparam int DEFAULT_WIDTH        = 12;
   localparam int DEFAULT_TICK_DIV     = 16000;
   localparam int DEFAULT_STABLE_TICKS = 4;

   // Board layout: eight slide switches, then four pushbuttons; button 8 doubles as the board reset.
   localparam int SW_FIRST  = 0;
   localparam int SW_LAST   = 7;
   localparam int BTN_FIRST = 8;
   localparam int BTN_LAST  = 11;
   localparam int RESET_BTN = 8;

   typedef enum logic {
      DB_STABLE   = 1'b0,
      DB_CHANGING = 1'b1
   } db_state_e;

   function automatic int cnt_width(input int ticks);
      return (ticks > 1) ? $clog2(ticks) : 1;
   endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO input bit: two-flop synchroniser, tick-based debounce counter, stable level and edge pulse.
module gpio_debounce_bit
   import gpio_in_debounce_pkg::*;
#(
   parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
   parameter bit BOTH_EDGES   = 1'b0
)
(
   input  logic clk,
   input  logic reset,
   input  logic pin,
   input  logic tick,
   output logic level,
   output logic edge_evt
);

   localparam int              CNT_W    = cnt_width(STABLE_TICKS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_TICKS - 1);

   logic             sync_meta;
   logic             sync;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             level_next;
   db_state_e        state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         sync_meta <= pin;
         sync      <= sync_meta;
      end
   end

   // Any cycle where the input agrees with the stable level discards the partial count.
   always_comb begin
      state      = (sync == level) ? DB_STABLE : DB_CHANGING;
      cnt_next   = cnt;
      level_next = level;
      if (state == DB_STABLE) begin
         cnt_next = '0;
      end else if (tick) begin
         if (cnt == LAST_CNT) begin
            level_next = sync;
            cnt_next   = '0;
         end else begin
            cnt_next = cnt + 1'b1;
         end
      end
   end

   assign edge_evt = BOTH_EDGES ? (level_next ^ level) : (level_next & ~level);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         cnt   <= cnt_next;
         level <= level_next;
      end
   end

endmodule

// File: rtl/gpio_in_debounce.sv
// GPIO input conditioning: per-bit debounce, shared sample prescaler, pending edge flags and one irq line.
// Define GPIO_IN_BOTH_EDGES_EN to latch falling as well as rising accepted changes.
module gpio_in_debounce
   import gpio_in_debounce_pkg::*;
#(
   parameter int WIDTH        = DEFAULT_WIDTH,
   parameter int TICK_DIV     = DEFAULT_TICK_DIV,
   parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pins_in,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] pending_out,
   input  logic [WIDTH-1:0] irq_en,
   input  logic             clr_valid,
   input  logic [WIDTH-1:0] clr_mask,
   output logic             irq
);

   localparam int               PRE_W    = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

`ifdef GPIO_IN_BOTH_EDGES_EN
   localparam bit BOTH_EDGES = 1'b1;
`else
   localparam bit BOTH_EDGES = 1'b0;
`endif

   logic [PRE_W-1:0] pre_cnt;
   logic             tick;
   logic [WIDTH-1:0] event_bits;
   logic [WIDTH-1:0] clr_bits;
   logic [WIDTH-1:0] pending;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt <= '0;
      end else if (pre_cnt == PRE_LAST) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   assign tick = (pre_cnt == PRE_LAST);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gpio_debounce_bit #(
         .STABLE_TICKS (STABLE_TICKS),
         .BOTH_EDGES   (BOTH_EDGES)
      ) u_bit (
         .clk      (clk),
         .reset    (reset),
         .pin      (pins_in[i]),
         .tick     (tick),
         .level    (level_out[i]),
         .edge_evt (event_bits[i])
      );
   end

   assign clr_bits = clr_valid ? clr_mask : '0;

   // A new event in the same cycle as its clear survives so no edge is ever lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
         irq     <= 1'b0;
      end else begin
         pending <= (pending & ~clr_bits) | event_bits;
         irq     <= |(pending & irq_en);
      end
   end

   assign pending_out = pending;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Scoreboard bench for gpio_in_debounce with TICK_DIV=4, STABLE_TICKS=3; expectations are queued per cycle.
module tb_gpio_in_debounce;

   localparam int WIDTH        = 12;
   localparam int TICK_DIV     = 4;
   localparam int STABLE_TICKS = 3;

`ifdef GPIO_IN_BOTH_EDGES_EN
   localparam bit BOTH = 1'b1;
`else
   localparam bit BOTH = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] pins_in;
   logic [WIDTH-1:0] level_out;
   logic [WIDTH-1:0] pending_out;
   logic [WIDTH-1:0] irq_en;
   logic             clr_valid;
   logic [WIDTH-1:0] clr_mask;
   logic             irq;

   typedef struct {
      int               cyc;
      logic [WIDTH-1:0] level;
      logic [WIDTH-1:0] pending;
      logic             irqV;
      string            tag;
   } exp_t;

   exp_t sbQueue[$];
   int   checkCount = 0;
   int   errorCount = 0;
   int   tcyc       = 0;
   int   rBase      = 0;

   always #5 clk = ~clk;

   gpio_in_debounce #(
      .WIDTH        (WIDTH),
      .TICK_DIV     (TICK_DIV),
      .STABLE_TICKS (STABLE_TICKS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pins_in     (pins_in),
      .level_out   (level_out),
      .pending_out (pending_out),
      .irq_en      (irq_en),
      .clr_valid   (clr_valid),
      .clr_mask    (clr_mask),
      .irq         (irq)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic pushExp(input int c, input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] pd,
                          input logic iq, input string tag);
      exp_t e;
      int   idx;
      e.cyc     = c;
      e.level   = lv;
      e.pending = pd;
      e.irqV    = iq;
      e.tag     = tag;
      idx       = sbQueue.size();
      for (int i = 0; i < sbQueue.size(); i++) begin
         if (sbQueue[i].cyc > c) begin
            idx = i;
            break;
         end
      end
      sbQueue.insert(idx, e);
   endtask

   // Advance one cycle and compare every expectation due at this negedge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      tcyc++;
      while (sbQueue.size() > 0 && sbQueue[0].cyc <= tcyc) begin
         e = sbQueue.pop_front();
         checkOutput({e.tag, "_level"},   32'(level_out),   32'(e.level));
         checkOutput({e.tag, "_pending"}, 32'(pending_out), 32'(e.pending));
         checkOutput({e.tag, "_irq"},     32'(irq),         32'(e.irqV));
      end
   endtask

   task automatic stepUntil(input int t);
      int guard;
      guard = 0;
      while (tcyc < t && guard < 2000) begin
         step();
         guard++;
      end
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] pinsVal);
      pins_in = pinsVal;
   endtask

   // Negedge at which a pin change driven at negedge tDrive shows up on level_out:
   // two sync flops, then the third tick update that falls on a posedge multiple of TICK_DIV.
   function automatic int acceptCycle(input int tDrive);
      int p;
      int f;
      p = tDrive - rBase + 1;
      f = ((p + 2 + TICK_DIV - 1) / TICK_DIV) * TICK_DIV;
      return rBase + f + (STABLE_TICKS - 1) * TICK_DIV;
   endfunction

   initial begin
      int t0;
      int tA;
      reset     = 1'b1;
      pins_in   = '0;
      irq_en    = '1;
      clr_valid = 1'b0;
      clr_mask  = '0;

      step();
      checkOutput("reset_level",   32'(level_out),   32'h0);
      checkOutput("reset_pending", 32'(pending_out), 32'h0);
      checkOutput("reset_irq",     32'(irq),         32'h0);
      pushExp(tcyc + 1, 12'h000, 12'h000, 1'b0, "reset_hold");
      step();
      reset = 1'b0;
      rBase = tcyc;
      step();
      step();

      // Five-cycle glitch on bit 3 never spans three ticks.
      t0 = tcyc;
      for (int i = 1; i <= 25; i++) pushExp(t0 + i, 12'h000, 12'h000, 1'b0, "glitch");
      applyStimulus(12'h008);
      repeat (5) step();
      applyStimulus(12'h000);
      stepUntil(t0 + 26);

      // Clean rise on bit 0.
      t0 = tcyc;
      applyStimulus(12'h001);
      tA = acceptCycle(t0);
      pushExp(tA - 1, 12'h000, 12'h000, 1'b0, "rise_pre");
      pushExp(tA,     12'h001, 12'h001, 1'b0, "rise_acc");
      pushExp(tA + 1, 12'h001, 12'h001, 1'b1, "rise_irq");
      stepUntil(tA + 2);

      // Write-one-to-clear, then a clear of already-clear bits.
      clr_valid = 1'b1;
      clr_mask  = 12'h001;
      pushExp(tcyc + 1, 12'h001, 12'h000, 1'b1, "w1c_pend");
      pushExp(tcyc + 2, 12'h001, 12'h000, 1'b0, "w1c_irq");
      step();
      clr_valid = 1'b0;
      clr_mask  = '0;
      step();
      clr_valid = 1'b1;
      clr_mask  = 12'hFFF;
      pushExp(tcyc + 1, 12'h001, 12'h000, 1'b0, "w1c_noop");
      step();
      clr_valid = 1'b0;
      clr_mask  = '0;

      // Falling change on bit 0.
      t0 = tcyc;
      applyStimulus(12'h000);
      tA = acceptCycle(t0);
      pushExp(tA - 1, 12'h001, 12'h000, 1'b0, "fall_pre");
      pushExp(tA,     12'h000, BOTH ? 12'h001 : 12'h000, 1'b0, "fall_acc");
      pushExp(tA + 1, 12'h000, BOTH ? 12'h001 : 12'h000, BOTH, "fall_irq");
      stepUntil(tA + 1);
      clr_valid = 1'b1;
      clr_mask  = 12'hFFF;
      pushExp(tcyc + 1, 12'h000, 12'h000, BOTH, "fall_clr");
      pushExp(tcyc + 2, 12'h000, 12'h000, 1'b0, "fall_clr_irq");
      step();
      clr_valid = 1'b0;
      clr_mask  = '0;
      step();

      // Rise on bit 0 coinciding with a clear of bit 0.
      t0 = tcyc;
      applyStimulus(12'h001);
      tA = acceptCycle(t0);
      pushExp(tA - 1, 12'h000, 12'h000, 1'b0, "race_pre");
      pushExp(tA,     12'h001, 12'h001, 1'b0, "race_set");
      pushExp(tA + 1, 12'h001, 12'h001, 1'b1, "race_irq");
      stepUntil(tA - 1);
      clr_valid = 1'b1;
      clr_mask  = 12'h001;
      step();
      clr_valid = 1'b0;
      clr_mask  = '0;
      step();
      clr_valid = 1'b1;
      clr_mask  = 12'h001;
      pushExp(tcyc + 1, 12'h001, 12'h000, 1'b1, "race_clr");
      pushExp(tcyc + 2, 12'h001, 12'h000, 1'b0, "race_clr_irq");
      step();
      clr_valid = 1'b0;
      clr_mask  = '0;
      step();

      // Masked event on bit 5, then enable it.
      irq_en = 12'h000;
      t0 = tcyc;
      applyStimulus(12'h021);
      tA = acceptCycle(t0);
      pushExp(tA - 1, 12'h001, 12'h000, 1'b0, "mask_pre");
      pushExp(tA,     12'h021, 12'h020, 1'b0, "mask_acc");
      pushExp(tA + 1, 12'h021, 12'h020, 1'b0, "mask_off");
      stepUntil(tA + 1);
      irq_en = 12'h020;
      pushExp(tcyc + 1, 12'h021, 12'h020, 1'b1, "mask_on");
      step();

      // Reset after two ticks of a change on bit 7; debounce restarts from scratch.
      t0 = tcyc;
      applyStimulus(12'h0A1);
      tA = acceptCycle(t0);
      stepUntil(tA - 2);
      reset = 1'b1;
      #1;
      checkOutput("rst_mid_level",   32'(level_out),   32'h0);
      checkOutput("rst_mid_pending", 32'(pending_out), 32'h0);
      checkOutput("rst_mid_irq",     32'(irq),         32'h0);
      step();
      step();
      reset = 1'b0;
      rBase = tcyc;
      tA = acceptCycle(tcyc);
      pushExp(rBase + 8, 12'h000, 12'h000, 1'b0, "rst_restart_mid");
      pushExp(tA - 1,    12'h000, 12'h000, 1'b0, "rst_restart_pre");
      pushExp(tA,        12'h0A1, 12'h0A1, 1'b0, "rst_restart_acc");
      pushExp(tA + 1,    12'h0A1, 12'h0A1, 1'b1, "rst_restart_irq");
      stepUntil(tA + 3);

      checkOutput("sb_empty", sbQueue.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
